// File: rtl/fdiv_exception_ctrl.sv
// fdiv_exception_ctrl: exception wrapper around an FP32 Newton-Raphson divider.
// Stage 0 classifies A/B, predicts exponent range and forwards benign operands.
// A valid-tagged delay line matched to the divider latency carries the verdict.
// The output stage merges the verdict with div_result into result and flags.
module fdiv_exception_ctrl #(
    parameter int DIV_LATENCY = 8,
    parameter bit FTZ         = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_result,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    localparam int          DEPTH    = DIV_LATENCY + 1;
    localparam logic [31:0] ONE      = 32'h3F80_0000;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [3:0]  F_INV    = 4'b1000;
    localparam logic [3:0]  F_DBZ    = 4'b0100;
    localparam logic [3:0]  F_OVF    = 4'b0010;
    localparam logic [3:0]  F_UNF    = 4'b0001;

    // Payload of one delay-line slot; its valid bit lives in valid_q.
    typedef struct packed {
        logic        special;
        logic [31:0] value;
        logic [3:0]  flags;
        logic        sign;
    } dl_entry_t;

    logic [7:0]        ea, eb;
    logic [22:0]       ma, mb;
    logic              a_zero, a_inf, a_nan;
    logic              b_zero, b_inf, b_nan;
    logic              s;
    logic signed [9:0] ep;
    logic              special;
    logic [31:0]       spec_value;
    logic [3:0]        spec_flags;

    logic [31:0]       div_a_d, div_a_q;
    logic [31:0]       div_b_d, div_b_q;
    logic [DEPTH-1:0]  valid_d, valid_q;
    dl_entry_t         dl_d [DEPTH];
    dl_entry_t         dl_q [DEPTH];
    dl_entry_t         tail;
    logic              out_valid_d, out_valid_q;
    logic [31:0]       result_d, result_q;
    logic [3:0]        flags_d, flags_q;

    // The quotient sign comes from the operands, so the divider's own sign is ignored.
    logic              unused_div_sign;
    assign unused_div_sign = div_result[31];

    // Stage 0: classify operands, predict the exponent, pick the special verdict.
    // NOTE: every variable gets a value at the top of the block so no path can infer a latch.
    always_comb begin
        ea     = A[30:23];
        eb     = B[30:23];
        ma     = A[22:0];
        mb     = B[22:0];
        a_zero = (ea == 8'd0) && ((ma == 23'd0) || FTZ);
        b_zero = (eb == 8'd0) && ((mb == 23'd0) || FTZ);
        a_inf  = (ea == 8'hFF) && (ma == 23'd0);
        b_inf  = (eb == 8'hFF) && (mb == 23'd0);
        a_nan  = (ea == 8'hFF) && (ma != 23'd0);
        b_nan  = (eb == 8'hFF) && (mb != 23'd0);
        s      = A[31] ^ B[31];
        ep     = 10'(ea) - 10'(eb) + 10'd127 - ((ma < mb) ? 10'd1 : 10'd0);

        special    = 1'b1;
        spec_value = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_value = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_value = QNAN;
            spec_flags = F_INV;
        end else if (a_inf) begin
            spec_value = {s, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_value = {s, 8'hFF, 23'd0};
            spec_flags = F_DBZ;
        end else if (a_zero || b_inf) begin
            spec_value = {s, 31'd0};
        end else if (ep > 10'sd254) begin
            spec_value = {s, 8'hFF, 23'd0};
            spec_flags = F_OVF;
        end else if (ep < 10'sd1) begin
            spec_value = {s, 31'd0};
            spec_flags = F_UNF;
        end else begin
            special = 1'b0;
        end

        // Only valid, benign operands reach the divider; everything else sees 1.0/1.0.
        div_a_d = (in_valid && !special) ? A : ONE;
        div_b_d = (in_valid && !special) ? B : ONE;
    end

    // Delay line next state: new verdict enters at slot 0, the rest shift by one.
    always_comb begin
        valid_d = {valid_q[DEPTH-2:0], in_valid};
        dl_d[0] = '{special: special, value: spec_value, flags: spec_flags, sign: s};
        for (int i = 1; i < DEPTH; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    // Divider operands and delay-line valid bits, cleared by reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            div_a_q <= '0;
            div_b_q <= '0;
            valid_q <= '0;
        end else begin
            div_a_q <= div_a_d;
            div_b_q <= div_b_d;
            valid_q <= valid_d;
        end
    end

    // Delay-line payload.
    // NOTE: the payload array has no reset; valid_q alone decides whether a slot is used.
    always_ff @(posedge clk) begin
        dl_q <= dl_d;
    end

    // Output merge: special verdict or divider quotient; hold result/flags on bubbles.
    always_comb begin
        tail        = dl_q[DEPTH-1];
        out_valid_d = valid_q[DEPTH-1];
        result_d    = result_q;
        flags_d     = flags_q;
        if (valid_q[DEPTH-1]) begin
            if (tail.special) begin
                result_d = tail.value;
                flags_d  = tail.flags;
            end else begin
                result_d = {tail.sign, div_result[30:0]};
                flags_d  = '0;
            end
        end
    end

    // Registered output stage.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv_exception_ctrl.sv
// Bench for fdiv_exception_ctrl: two instances (FTZ=1 and FTZ=0), each fed by a
// behavioural 8-cycle divider. Expected results come from a vector table and a
// scoreboard queue that also checks the fixed issue-to-output latency.
module tb_fdiv_exception_ctrl;

    localparam int          LAT       = 8;
    localparam int          OUT_DELAY = LAT + 1;
    localparam logic [31:0] ONE       = 32'h3F80_0000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        valid;
        logic [31:0] exp_result;
        logic [3:0]  exp_flags;
        logic        to_div;
    } vec_t;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        int          issue_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] a, b;

    logic [31:0] div_a0, div_b0, div_result0, result0;
    logic [31:0] div_a1, div_b1, div_result1, result1;
    logic        out_valid0, out_valid1;
    logic [3:0]  flags0, flags1;

    logic [31:0] dpipe0 [LAT];
    logic [31:0] dpipe1 [LAT];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    exp_t        sb [$];
    logic [31:0] last_res = '0;
    logic [3:0]  last_flags = '0;
    vec_t        vecs [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fdiv_exception_ctrl #(.DIV_LATENCY(LAT), .FTZ(1'b1)) dut_ftz (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .A(a), .B(b),
        .div_a(div_a0), .div_b(div_b0), .div_result(div_result0),
        .out_valid(out_valid0), .result(result0), .flags(flags0)
    );

    fdiv_exception_ctrl #(.DIV_LATENCY(LAT), .FTZ(1'b0)) dut_noftz (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .A(a), .B(b),
        .div_a(div_a1), .div_b(div_b1), .div_result(div_result1),
        .out_valid(out_valid1), .result(result1), .flags(flags1)
    );

    function automatic real fp_to_real(input logic [31:0] x);
        real r;
        int  e;
        if (x[30:23] == 8'd0) return 0.0;
        r = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        if (x[31]) r = -r;
        return r;
    endfunction

    function automatic logic [31:0] real_to_fp(input real q);
        logic [63:0] d;
        int          e;
        if (q == 0.0) return 32'd0;
        d = $realtobits(q);
        e = int'(d[62:52]) - 1023 + 127;
        if (e < 1 || e > 254) return {d[63], 31'd0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fdiv_model(input logic [31:0] x, input logic [31:0] y);
        return real_to_fp(fp_to_real(x) / fp_to_real(y));
    endfunction

    // Behavioural dividers: quotient of the registered operands, LAT cycles later.
    initial begin
        for (int i = 0; i < LAT; i++) begin
            dpipe0[i] = '0;
            dpipe1[i] = '0;
        end
    end

    always @(posedge clk) begin
        dpipe0[0] <= fdiv_model(div_a0, div_b0);
        dpipe1[0] <= fdiv_model(div_a1, div_b1);
        for (int i = 1; i < LAT; i++) begin
            dpipe0[i] <= dpipe0[i-1];
            dpipe1[i] <= dpipe1[i-1];
        end
    end
    assign div_result0 = dpipe0[LAT-1];
    assign div_result1 = dpipe1[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic v,
                                input logic [31:0] res, input logic [3:0] fl, input logic td);
        vec_t t;
        t.a = va; t.b = vb; t.valid = v; t.exp_result = res; t.exp_flags = fl; t.to_div = td;
        return t;
    endfunction

    // Drive one cycle of stimulus, record the expectation and check the divider operands.
    task automatic issue(input vec_t v);
        exp_t e;
        in_valid = v.valid;
        a        = v.a;
        b        = v.b;
        @(posedge clk);
        #1;
        if (v.valid) begin
            e.result    = v.exp_result;
            e.flags     = v.exp_flags;
            e.issue_cyc = cyc;
            sb.push_back(e);
        end
        check("div_a", div_a0, (v.valid && v.to_div) ? v.a : ONE);
        check("div_b", div_b0, (v.valid && v.to_div) ? v.b : ONE);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(mk(32'd0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0));
    endtask

    // Scoreboard monitor: out_valid must rise exactly OUT_DELAY edges after issue,
    // result/flags must match on valid cycles and hold on bubble cycles.
    always @(negedge clk) begin
        logic exp_v;
        exp_t e;
        if (mon_en) begin
            exp_v = (sb.size() > 0) && (sb[0].issue_cyc + OUT_DELAY == cyc);
            check("out_valid", 32'(out_valid0), 32'(exp_v));
            if (exp_v) begin
                e = sb.pop_front();
                last_res   = e.result;
                last_flags = e.flags;
            end
            check("result", result0, last_res);
            check("flags", 32'(flags0), 32'(last_flags));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid0), 32'd0);
        check("reset result", result0, 32'd0);
        check("reset flags", 32'(flags0), 32'd0);
        check("reset div_a", div_a0, 32'd0);
        check("reset div_b", div_b0, 32'd0);
        reset_n = 1'b0;
        mon_en  = 1'b1;

        // Single normal operation: 6.0 / 2.0 = 3.0.
        issue(mk(32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 4'b0000, 1'b1));
        idle(12);

        // Specials back to back, range cases, boundaries, then a gapped normal stream.
        vecs.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h7FC0_0000, 4'b1000, 1'b0));
        vecs.push_back(mk(32'h3F80_0000, 32'h0000_0000, 1'b1, 32'h7F80_0000, 4'b0100, 1'b0));
        vecs.push_back(mk(32'hBF80_0000, 32'h0000_0000, 1'b1, 32'hFF80_0000, 4'b0100, 1'b0));
        vecs.push_back(mk(32'h7FA0_0000, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 4'b0000, 1'b0));
        vecs.push_back(mk(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b1000, 1'b0));
        vecs.push_back(mk(32'h7F00_0000, 32'h0080_0000, 1'b1, 32'h7F80_0000, 4'b0010, 1'b0));
        vecs.push_back(mk(32'h0080_0000, 32'h7F00_0000, 1'b1, 32'h0000_0000, 4'b0001, 1'b0));
        vecs.push_back(mk(32'hC0C0_0000, 32'h4000_0000, 1'b1, 32'hC040_0000, 4'b0000, 1'b1));
        vecs.push_back(mk(32'h4000_0000, 32'h7F80_0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'h4000_0000, 1'b1, 32'h8000_0000, 4'b0000, 1'b0));
        vecs.push_back(mk(32'h7F80_0000, 32'hC000_0000, 1'b1, 32'hFF80_0000, 4'b0000, 1'b0));
        vecs.push_back(mk(32'h7F00_0000, 32'h3F80_0000, 1'b1, 32'h7F00_0000, 4'b0000, 1'b1));
        vecs.push_back(mk(32'h7F7F_FFFF, 32'h3F00_0000, 1'b1, 32'h7F80_0000, 4'b0010, 1'b0));
        vecs.push_back(mk(32'h0080_0000, 32'h3F80_0000, 1'b1, 32'h0080_0000, 4'b0000, 1'b1));
        vecs.push_back(mk(32'h0080_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 4'b0001, 1'b0));
        vecs.push_back(mk(32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 4'b0000, 1'b1));
        vecs.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0));
        vecs.push_back(mk(32'h4100_0000, 32'h4000_0000, 1'b1, 32'h4080_0000, 4'b0000, 1'b1));
        vecs.push_back(mk(32'h4040_0000, 32'h4000_0000, 1'b1, 32'h3FC0_0000, 4'b0000, 1'b1));
        vecs.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0));
        vecs.push_back(mk(32'h3F80_0000, 32'h4080_0000, 1'b1, 32'h3E80_0000, 4'b0000, 1'b1));
        foreach (vecs[i]) issue(vecs[i]);
        idle(12);

        // Denormal dividend: flushed to zero with FTZ=1, underflow path with FTZ=0.
        issue(mk(32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b0));
        check("noftz div_a", div_a1, ONE);
        check("noftz div_b", div_b1, ONE);
        idle(9);
        check("noftz out_valid", 32'(out_valid1), 32'd1);
        check("noftz result", result1, 32'h0000_0000);
        check("noftz flags", 32'(flags1), 32'(4'b0001));
        idle(1);
        check("noftz out_valid drop", 32'(out_valid1), 32'd0);
        idle(10);

        // Reset mid-flight: three ops in flight plus a fourth on the reset edge are dropped.
        for (int i = 0; i < 3; i++)
            issue(mk(32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 4'b0000, 1'b1));
        in_valid = 1'b1;
        a        = 32'h4100_0000;
        b        = 32'h4000_0000;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        last_res   = '0;
        last_flags = '0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        check("midreset out_valid", 32'(out_valid0), 32'd0);
        check("midreset result", result0, 32'd0);
        check("midreset flags", 32'(flags0), 32'd0);
        check("midreset div_a", div_a0, 32'd0);
        issue(mk(32'hC0C0_0000, 32'h4000_0000, 1'b1, 32'hC040_0000, 4'b0000, 1'b1));
        idle(14);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fdiv_exception_ctrl.md
Name: fdiv_exception_ctrl

Overview:
- Front/back wrapper stage placed directly upstream of the FP32 Newton-Raphson divider.
- Classifies operands A and B as zero, denormal, infinity, NaN or normal.
- Sends only benign operands to the divider and predicts exponent overflow/underflow, which the divider does not handle.
- Carries the special-case verdict down a valid-tagged delay line matched to the divider latency, then merges it with the divider output into one registered result plus IEEE-style flags.

Parameters:
- DIV_LATENCY, 8, cycles from div_a/div_b change to the matching div_result.
- FTZ, 1, 1 = denormal inputs treated as signed zero; 0 = denormals treated as normal (no special handling).

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, synchronous reset, active-high despite the codebase name (asserted = 1).
- in_valid, input, 1, A/B valid this cycle; one operation accepted per cycle; no backpressure.
- A, input, 32, dividend, FP32.
- B, input, 32, divisor, FP32.
- div_a, output, 32, registered dividend to the divider.
- div_b, output, 32, registered divisor to the divider.
- div_result, input, 32, divider quotient, DIV_LATENCY cycles after div_a/div_b.
- out_valid, output, 1, result/flags valid.
- result, output, 32, final FP32 quotient.
- flags, output, 4, {invalid, div_by_zero, overflow, underflow}, valid with out_valid.

Behaviour:
- Reset (reset_n=1 at posedge): div_a, div_b, result and flags go to 0; out_valid and every delay-line valid bit go to 0; all in-flight operations are dropped. The first output after reset release comes only from operations accepted after release.
- Stage 0 (registered, 1 cycle):
  - Classify. zero: exp==0 && (man==0 || FTZ). inf: exp==255 && man==0. nan: exp==255 && man!=0.
  - s = A[31]^B[31].
  - Predicted exponent, 10-bit signed: ep = ea - eb + 127 - (ma<mb ? 1 : 0), where ma/mb are 23-bit fractions.
- Special-case priority (first match wins). A special verdict forces div_a = div_b = 0x3F800000.
  1. A or B NaN -> 0x7FC00000, no flag.
  2. 0/0 or inf/inf -> 0x7FC00000, invalid.
  3. inf/x -> {s, 0xFF, 0}.
  4. x/0 (x finite nonzero) -> {s, 0xFF, 0}, div_by_zero.
  5. 0/x or x/inf -> {s, 31'b0}.
  6. ep>254 -> {s, 0xFF, 0}, overflow.
  7. ep<1 -> {s, 31'b0}, underflow.
  8. Otherwise normal: div_a=A, div_b=B, result taken from the divider.
- Delay line: DIV_LATENCY+1 entries of {valid, special, special_value[31:0], flags[3:0], s}. It shifts every cycle. An entry's valid bit is in_valid registered.
- Output stage (registered):
  - If the tail entry is valid and special: result = special_value.
  - If valid and normal: result = {s, div_result[30:0]}, flags = 0.
  - out_valid = tail valid.
  - When tail valid = 0: out_valid = 0; result and flags hold their previous values.
- Latency: in_valid at edge N -> out_valid high in the cycle after edge N+DIV_LATENCY+1, i.e. DIV_LATENCY+2 cycles. Fixed for every case, special or normal.
- Throughput: 1 per cycle. Back-to-back and gapped inputs keep their order. in_valid gaps produce out_valid gaps at the same positions.
- in_valid=0: stage 0 still registers safe operands (0x3F800000) and the valid bit is 0.

Test Plan:
- DIV_LATENCY=8, behavioural divider model with 8-cycle delay. A=0x40C00000 (6.0), B=0x40000000 (2.0), single pulse -> exactly 10 cycles later out_valid=1, result=0x40400000, flags=0.
- Specials, back-to-back, one per cycle:
  - 0/0 -> 0x7FC00000, flags=1000.
  - 1.0/+0 (0x3F800000/0x00000000) -> 0x7F800000, flags=0100.
  - -1.0/+0 -> 0xFF800000, flags=0100.
  - NaN 0x7FA00000 / 1.0 -> 0x7FC00000, flags=0000.
  - inf/inf -> 0x7FC00000, flags=1000.
  - Required: five consecutive out_valid cycles, in this order, and div_a = div_b = 0x3F800000 for each.
- Range:
  - A=0x7F000000 / B=0x00800000 -> 0x7F800000, overflow (0010).
  - A=0x00800000 / B=0x7F000000 -> 0x00000000, underflow (0001).
  - A=0xC0C00000 / B=0x40000000 -> 0xC0400000.
- Gaps: pattern in_valid 1,0,1,1,0,1 of normal ops -> out_valid shows the same 1,0,1,1,0,1 pattern, starting 10 cycles later, with the correct quotients in order.
- Reset mid-flight: issue 4 ops, assert reset_n for 1 cycle at cycle 3 -> no out_valid for those ops; outputs read 0. An op issued right after release appears 10 cycles after issue.
- FTZ: A=0x00000001, B=1.0. FTZ=1 -> 0x00000000, flags=0, divider not used. FTZ=0 -> underflow path, result 0x00000000, flags=0001.
